// File: rtl/rv32_pkg.sv
// Shared types and constants for the memory port arbiter.
// Contents: arbiter state enum, owner enum, control no-op code, memory request
// payload struct and a store-detect helper.
package rv32_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CTRL_W = 3;

  // Control code meaning "no access of this kind".
  localparam logic [CTRL_W-1:0] CTRL_NOP = 3'd7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    D_BUSY  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_t;

  // Fields presented to the memory for one access.
  typedef struct packed {
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic [CTRL_W-1:0] readcontrol;
    logic [CTRL_W-1:0] writecontrol;
  } mem_req_t;

  function automatic logic is_store_op(input logic [CTRL_W-1:0] wc);
    return wc != CTRL_NOP;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the memory.
// Modports:
//   slave  - arbiter view: requests and memory response in, grants,
//            completions and memory command out.
//   master - environment view: the mirror image of slave.
interface mem_port_arbiter_if;
  import rv32_pkg::*;

  logic              if_req;
  logic [XLEN-1:0]   if_addr;
  logic              if_gnt;
  logic              if_valid;
  logic [XLEN-1:0]   if_rdata;

  logic              d_req;
  logic [XLEN-1:0]   d_addr;
  logic [XLEN-1:0]   d_wdata;
  logic [CTRL_W-1:0] d_readcontrol;
  logic [CTRL_W-1:0] d_writecontrol;
  logic              d_gnt;
  logic              d_valid;
  logic [XLEN-1:0]   d_rdata;

  logic              mem_en;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [CTRL_W-1:0] mem_readcontrol;
  logic [CTRL_W-1:0] mem_writecontrol;
  logic [XLEN-1:0]   mem_rdata;
  logic              mem_ready;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_addr, d_wdata, d_readcontrol, d_writecontrol,
    input  mem_rdata, mem_ready,
    output if_gnt, if_valid, if_rdata,
    output d_gnt, d_valid, d_rdata,
    output mem_en, mem_addr, mem_wdata, mem_readcontrol, mem_writecontrol
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_addr, d_wdata, d_readcontrol, d_writecontrol,
    output mem_rdata, mem_ready,
    input  if_gnt, if_valid, if_rdata,
    input  d_gnt, d_valid, d_rdata,
    input  mem_en, mem_addr, mem_wdata, mem_readcontrol, mem_writecontrol
  );

endinterface

// File: rtl/mem_arb_timer.sv
// Busy-cycle counter for the memory port arbiter.
// Ports: clk, rst (sync, active high); clear zeroes the count; enable counts
// one busy cycle; expired is high during the TIMEOUT_CYC-th enabled cycle.
module mem_arb_timer #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt;

  // Count completed busy cycles; holds once the limit is hit.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Decoded from the registered count so the abort lands on the last busy cycle.
  assign expired = enable && (cnt == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch and data accesses.
// Ports: clk, rst (sync, active high), hlt (blocks new grants), bus
// (mem_port_arbiter_if.slave: fetch/data requests, grants, completions and
// memory command/response), err (sticky timeout flag).
// Grants are issued combinationally from IDLE; everything else is registered.
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin on contention,
// otherwise data has fixed priority over fetch.
module mem_port_arbiter
  import rv32_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hlt,
  mem_port_arbiter_if.slave bus,
  output logic              err
);

  arb_state_t      state;
  logic            is_store;
  logic            busy;
  logic            expired;
  logic            grant_c;
  logic            pick_d_c;
  logic [XLEN-1:0] rsp_data_c;
  mem_req_t        req_sel_c;

  assign busy    = (state != IDLE);
  assign grant_c = !rst && !hlt && (state == IDLE) && (bus.if_req || bus.d_req);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  arb_owner_t last_owner;

  // Reset to fetch so that data wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner <= OWN_IF;
    end else if (grant_c) begin
      last_owner <= pick_d_c ? OWN_D : OWN_IF;
    end
  end

  assign pick_d_c = bus.d_req && (!bus.if_req || (last_owner == OWN_IF));
`else
  assign pick_d_c = bus.d_req;
`endif

  assign bus.d_gnt  = grant_c && pick_d_c;
  assign bus.if_gnt = grant_c && !pick_d_c;

  // Memory command for the requester about to be granted.
  always_comb begin
    req_sel_c.addr         = bus.if_addr;
    req_sel_c.wdata        = '0;
    req_sel_c.readcontrol  = CTRL_NOP;
    req_sel_c.writecontrol = CTRL_NOP;
    if (pick_d_c) begin
      req_sel_c.addr         = bus.d_addr;
      req_sel_c.wdata        = bus.d_wdata;
      req_sel_c.writecontrol = bus.d_writecontrol;
      req_sel_c.readcontrol  = is_store_op(bus.d_writecontrol) ? CTRL_NOP : bus.d_readcontrol;
    end
  end

  // Stores and timeouts complete with zero data.
  assign rsp_data_c = (bus.mem_ready && !is_store) ? bus.mem_rdata : '0;

  mem_arb_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (!busy),
    .enable (busy),
    .expired(expired)
  );

  // Arbiter FSM with registered memory command and completion outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      is_store             <= 1'b0;
      err                  <= 1'b0;
      bus.if_valid         <= 1'b0;
      bus.if_rdata         <= '0;
      bus.d_valid          <= 1'b0;
      bus.d_rdata          <= '0;
      bus.mem_en           <= 1'b0;
      bus.mem_addr         <= '0;
      bus.mem_wdata        <= '0;
      bus.mem_readcontrol  <= CTRL_NOP;
      bus.mem_writecontrol <= CTRL_NOP;
    end else begin
      bus.if_valid <= 1'b0;
      bus.d_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_c) begin
            state                <= pick_d_c ? D_BUSY : IF_BUSY;
            is_store             <= pick_d_c && is_store_op(bus.d_writecontrol);
            bus.mem_en           <= 1'b1;
            bus.mem_addr         <= req_sel_c.addr;
            bus.mem_wdata        <= req_sel_c.wdata;
            bus.mem_readcontrol  <= req_sel_c.readcontrol;
            bus.mem_writecontrol <= req_sel_c.writecontrol;
          end
        end
        IF_BUSY, D_BUSY: begin
          // mem_ready wins over a timeout landing in the same cycle.
          if (bus.mem_ready || expired) begin
            state                <= IDLE;
            bus.mem_en           <= 1'b0;
            bus.mem_readcontrol  <= CTRL_NOP;
            bus.mem_writecontrol <= CTRL_NOP;
            if (!bus.mem_ready) begin
              err <= 1'b1;
            end
            if (state == IF_BUSY) begin
              bus.if_valid <= 1'b1;
              bus.if_rdata <= rsp_data_c;
            end else begin
              bus.d_valid <= 1'b1;
              bus.d_rdata <= rsp_data_c;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized fetch/load/store traffic checked against a transaction model.
module tb_mem_port_arbiter;

  localparam int unsigned TO  = 16;
  localparam logic [2:0]  NOP = 3'd7;

  logic clk;
  logic rst;
  logic hlt;
  logic err;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hlt(hlt),
    .bus(bus),
    .err(err)
  );

  int vectors;
  int miscompares;
  bit m_err;
  bit m_last_d;
  bit rand_hlt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end of run, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Winner of the current request pattern according to the arbitration rule.
  function automatic bit pick_d(input bit rif, input bit rd);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (rif && rd) return !m_last_d;
    return rd;
`else
    return rd;
`endif
  endfunction

  // Called in the grant cycle; returns in the completion (valid) cycle.
  task automatic serve(input bit own_d, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [2:0] rc, input logic [2:0] wc,
                       input int rdy, input logic [31:0] rd);
    bit store;
    bit timed_out;
    int last_b;
    logic [2:0] erc;
    logic [2:0] ewc;
    logic [31:0] exp_rd;
    store     = own_d && (wc != NOP);
    erc       = (!own_d || store) ? NOP : rc;
    ewc       = own_d ? wc : NOP;
    timed_out = !(rdy >= 1 && rdy <= int'(TO));
    last_b    = timed_out ? int'(TO) : rdy;
    for (int b = 1; b <= last_b; b++) begin
      next_cycle();
      if (own_d) begin
        bus.d_req  = 1'b0;
        bus.d_addr = $urandom;
      end else begin
        bus.if_req  = 1'b0;
        bus.if_addr = $urandom;
      end
      if (rand_hlt) hlt = 1'($urandom_range(0, 1));
      bus.mem_ready = (b == rdy);
      bus.mem_rdata = (b == rdy) ? rd : $urandom;
      #2;
      chk("busy_mem_en", 32'(bus.mem_en), 32'(1));
      chk("busy_mem_addr", bus.mem_addr, addr);
      chk("busy_mem_rc", 32'(bus.mem_readcontrol), 32'(erc));
      chk("busy_mem_wc", 32'(bus.mem_writecontrol), 32'(ewc));
      if (store) chk("busy_mem_wdata", bus.mem_wdata, wd);
      chk("busy_valids", 32'({bus.if_valid, bus.d_valid}), 32'(0));
      chk("busy_gnts", 32'({bus.if_gnt, bus.d_gnt}), 32'(0));
    end
    next_cycle();
    bus.mem_ready = 1'b0;
    hlt = 1'b0;
    #2;
    if (timed_out) m_err = 1'b1;
    exp_rd = (timed_out || store) ? 32'h0 : rd;
    chk("done_if_valid", 32'(bus.if_valid), 32'(!own_d));
    chk("done_d_valid", 32'(bus.d_valid), 32'(own_d));
    if (own_d) chk("done_d_rdata", bus.d_rdata, exp_rd);
    else       chk("done_if_rdata", bus.if_rdata, exp_rd);
    chk("done_mem_en", 32'(bus.mem_en), 32'(0));
    chk("done_mem_rc", 32'(bus.mem_readcontrol), 32'(NOP));
    chk("done_mem_wc", 32'(bus.mem_writecontrol), 32'(NOP));
    chk("done_err", 32'(err), 32'(m_err));
  endtask

  // Present requests in a fresh cycle, check grants, serve winner then loser.
  task automatic access(input bit rif, input bit rd, input logic [31:0] ia,
                        input logic [31:0] da, input logic [31:0] wd,
                        input logic [2:0] rc, input logic [2:0] wc,
                        input int rdy1, input logic [31:0] dat1,
                        input int rdy2, input logic [31:0] dat2);
    bit w;
    next_cycle();
    hlt                = 1'b0;
    bus.mem_ready      = 1'b0;
    bus.if_req         = rif;
    bus.if_addr        = ia;
    bus.d_req          = rd;
    bus.d_addr         = da;
    bus.d_wdata        = wd;
    bus.d_readcontrol  = rc;
    bus.d_writecontrol = wc;
    #2;
    w = pick_d(rif, rd);
    chk("gnt_if", 32'(bus.if_gnt), 32'(!w));
    chk("gnt_d", 32'(bus.d_gnt), 32'(w));
    m_last_d = w;
    serve(w, w ? da : ia, wd, rc, wc, rdy1, dat1);
    if (rif && rd) begin
      chk("gnt2_if", 32'(bus.if_gnt), 32'(w));
      chk("gnt2_d", 32'(bus.d_gnt), 32'(!w));
      m_last_d = !w;
      serve(!w, w ? ia : da, wd, rc, wc, rdy2, dat2);
    end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
  endtask

  int r;
  int rdy_a;
  int rdy_b;
  logic [2:0] rc_r;
  logic [2:0] wc_r;

  initial begin
    vectors            = 0;
    miscompares        = 0;
    m_err              = 1'b0;
    m_last_d           = 1'b0;
    rand_hlt           = 1'b0;
    rst                = 1'b1;
    hlt                = 1'b0;
    bus.if_req         = 1'b0;
    bus.if_addr        = '0;
    bus.d_req          = 1'b0;
    bus.d_addr         = '0;
    bus.d_wdata        = '0;
    bus.d_readcontrol  = NOP;
    bus.d_writecontrol = NOP;
    bus.mem_rdata      = '0;
    bus.mem_ready      = 1'b0;

    // Reset values, with requests present to show no grant under reset.
    repeat (2) @(posedge clk);
    #1;
    bus.if_req = 1'b1;
    bus.d_req  = 1'b1;
    #2;
    chk("rst_gnts", 32'({bus.if_gnt, bus.d_gnt}), 32'(0));
    chk("rst_valids", 32'({bus.if_valid, bus.d_valid}), 32'(0));
    chk("rst_if_rdata", bus.if_rdata, 32'h0);
    chk("rst_d_rdata", bus.d_rdata, 32'h0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'(0));
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_mem_rc", 32'(bus.mem_readcontrol), 32'(NOP));
    chk("rst_mem_wc", 32'(bus.mem_writecontrol), 32'(NOP));
    chk("rst_err", 32'(err), 32'(0));
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    rst        = 1'b0;

    // Single fetch, ready in the third busy cycle.
    access(1'b1, 1'b0, 32'h100, 32'h0, 32'h0, NOP, NOP, 3, 32'h0050_0093, 0, 32'h0);

    // Contention three times: fixed priority or alternation.
    access(1'b1, 1'b1, 32'h200, 32'h300, 32'h0, 3'd2, NOP, 2, 32'h1111_2222, 4, 32'h3333_4444);
    access(1'b1, 1'b1, 32'h204, 32'h304, 32'h0, 3'd2, NOP, 1, 32'h5555_6666, 3, 32'h7777_8888);
    access(1'b1, 1'b1, 32'h208, 32'h308, 32'h0, 3'd2, NOP, 5, 32'h9999_AAAA, 1, 32'hBBBB_CCCC);

    // Store: readcontrol forced to no-op, completion data zero.
    access(1'b0, 1'b1, 32'h0, 32'h400, 32'hCAFE_BABE, 3'd0, 3'd2, 2, 32'h1234_5678, 0, 32'h0);

    // Timeout with no mem_ready, then err must stay set across a good access.
    access(1'b1, 1'b0, 32'h600, 32'h0, 32'h0, NOP, NOP, 0, 32'h0, 0, 32'h0);
    access(1'b0, 1'b1, 32'h0, 32'h700, 32'h0, 3'd4, NOP, 2, 32'h0BAD_F00D, 0, 32'h0);

    // Halt blocks grants; the grant appears in the cycle halt falls.
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      hlt        = 1'b1;
      bus.if_req = 1'b1;
      #2;
      chk("hlt_no_gnt", 32'({bus.if_gnt, bus.d_gnt}), 32'(0));
    end
    access(1'b1, 1'b0, 32'h800, 32'h0, 32'h0, NOP, NOP, 2, 32'h0000_0ABC, 0, 32'h0);

    // Reset mid-access, then a late mem_ready.
    next_cycle();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h500;
    #2;
    chk("mid_gnt", 32'(bus.if_gnt), 32'(1));
    next_cycle();
    bus.if_req = 1'b0;
    #2;
    chk("mid_mem_en", 32'(bus.mem_en), 32'(1));
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst           = 1'b0;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    #2;
    m_err    = 1'b0;
    m_last_d = 1'b0;
    chk("mid_rst_valids", 32'({bus.if_valid, bus.d_valid}), 32'(0));
    chk("mid_rst_mem_en", 32'(bus.mem_en), 32'(0));
    chk("mid_rst_rc", 32'(bus.mem_readcontrol), 32'(NOP));
    chk("mid_rst_wc", 32'(bus.mem_writecontrol), 32'(NOP));
    chk("mid_rst_err", 32'(err), 32'(0));
    next_cycle();
    #2;
    chk("late_rdy_valids", 32'({bus.if_valid, bus.d_valid}), 32'(0));
    chk("late_rdy_mem_en", 32'(bus.mem_en), 32'(0));
    bus.mem_ready = 1'b0;
    access(1'b1, 1'b0, 32'h900, 32'h0, 32'h0, NOP, NOP, 1, 32'h0000_0900, 0, 32'h0);

    // Randomized traffic, halt toggling while busy.
    rand_hlt = 1'b1;
    for (int i = 0; i < 30; i++) begin
      r     = int'($urandom_range(1, 3));
      rc_r  = 3'($urandom_range(0, 6));
      wc_r  = ($urandom_range(0, 1) == 0) ? NOP : 3'($urandom_range(0, 6));
      rdy_a = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
      rdy_b = int'($urandom_range(1, 6));
      access(r[0], r[1], $urandom, $urandom, $urandom, rc_r, wc_r,
             rdy_a, $urandom, rdy_b, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
